// File: rtl/mmul_parallel_package.sv
// Shared types and constants for the mmul_parallel operand feeders.
package mmul_parallel_package;

  localparam int unsigned LANE_DIST_N_LANES   = 16;
  localparam int unsigned LANE_DIST_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } lane_dist_state_e;

endpackage

// File: rtl/mmul_parallel_lane_slot.sv
// One-entry lane holding register; a reload in the same cycle as a drain keeps the lane full.
module mmul_parallel_lane_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (clear_i) begin
      valid_reg <= 1'b0;
    end else if (load_i) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data_i;
    end else if (ready_i) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid_o = valid_reg;
  assign data_o  = data_reg;

endmodule

// File: rtl/mmul_parallel_lane_distributor.sv
// Round-robin scalar-to-lane distributor with job word counting.
// Optional stall counter output enabled by MMUL_PARALLEL_LANE_DIST_PERF_EN.
module mmul_parallel_lane_distributor
  import mmul_parallel_package::*;
#(
  parameter int unsigned N_LANES    = LANE_DIST_N_LANES,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = LANE_DIST_CNT_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [CNT_WIDTH-1:0]          len_i,
  input  logic [DATA_WIDTH-1:0]         in_data_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  output logic [N_LANES*DATA_WIDTH-1:0] lane_data_o,
  output logic [N_LANES-1:0]            lane_valid_o,
  input  logic [N_LANES-1:0]            lane_ready_i,
  output logic                          busy_o,
`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
  output logic [31:0]                   stall_cnt_o,
`endif
  output logic                          done_o
);

  localparam int unsigned PTR_WIDTH = $clog2(N_LANES);

  lane_dist_state_e       state_reg, state_next;
  logic [PTR_WIDTH-1:0]   ptr_reg, ptr_next;
  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0]   len_reg, len_next;
  logic [N_LANES-1:0]     lane_valid;
  logic [N_LANES-1:0]     lane_load;
  logic                   accept;
  logic                   last_word;

  // Ready depends only on the targeted lane, never on in_valid_i.
  assign in_ready_o = (state_reg == RUN) &&
                      (!lane_valid[ptr_reg] || lane_ready_i[ptr_reg]);
  assign accept     = in_valid_i && in_ready_o;
  assign last_word  = (cnt_reg == len_reg - CNT_WIDTH'(1));

  genvar gi;
  generate
    for (gi = 0; gi < N_LANES; gi++) begin : g_lane
      assign lane_load[gi] = accept && (ptr_reg == PTR_WIDTH'(gi));

      mmul_parallel_lane_slot #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_slot (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .load_i     (lane_load[gi]),
        .load_data_i(in_data_i),
        .ready_i    (lane_ready_i[gi]),
        .valid_o    (lane_valid[gi]),
        .data_o     (lane_data_o[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            len_next   = len_i;
            ptr_next   = '0;
            cnt_next   = '0;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        if (accept) begin
          ptr_next = ptr_reg + PTR_WIDTH'(1);
          cnt_next = cnt_reg + CNT_WIDTH'(1);
          if (last_word) state_next = DRAIN;
        end
      end
      // No loads happen here, so the post-update valids are valid & ~ready.
      DRAIN: begin
        if ((lane_valid & ~lane_ready_i) == '0) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
      ptr_next   = '0;
      cnt_next   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
    end
  end

  assign lane_valid_o = lane_valid;
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);

`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
  logic [31:0] stall_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_reg <= '0;
    end else if (clear_i || ((state_reg == IDLE) && start_i)) begin
      stall_reg <= '0;
    end else if ((state_reg == RUN) && in_valid_i && !in_ready_o && (stall_reg != '1)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_reg;
`endif

endmodule

// File: tb/tb_mmul_parallel_lane_distributor.sv
// Directed bench for mmul_parallel_lane_distributor; stall counter checks under MMUL_PARALLEL_LANE_DIST_PERF_EN.
module tb_mmul_parallel_lane_distributor;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int CW = 16;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [CW-1:0]   len_i = '0;
  logic [DW-1:0]   in_data_i = '0;
  logic            in_valid_i = 1'b0;
  logic            in_ready_o;
  logic [N*DW-1:0] lane_data_o;
  logic [N-1:0]    lane_valid_o;
  logic [N-1:0]    lane_ready_i = '0;
  logic            busy_o;
  logic            done_o;
`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
  logic [31:0]     stall_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  mmul_parallel_lane_distributor dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .lane_data_o (lane_data_o),
    .lane_valid_o(lane_valid_o),
    .lane_ready_i(lane_ready_i),
    .busy_o      (busy_o),
`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_word(input int k);
    return lane_data_o[k*DW +: DW];
  endfunction

  // Full job with every lane ready; optionally pulses a stray start (len 5) mid-run.
  task automatic run_job(input int len, input logic [DW-1:0] base, input int pulse_at);
    len_i   = CW'(len);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("job_busy", 64'(busy_o), 64'd1);
    for (int i = 0; i < len; i++) begin
      chk("job_ready", 64'(in_ready_o), 64'd1);
      if (i == pulse_at) begin
        start_i = 1'b1;
        len_i   = CW'(5);
      end
      in_data_i  = base + DW'(i);
      in_valid_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("job_onehot", 64'(lane_valid_o), 64'(16'h1 << (i % N)));
      chk("job_data", 64'(lane_word(i % N)), 64'(base + DW'(i)));
    end
    in_valid_i = 1'b0;
    chk("job_drain_ready", 64'(in_ready_o), 64'd0);
    chk("job_drain_done", 64'(done_o), 64'd0);
    chk("job_drain_busy", 64'(busy_o), 64'd1);
    tick();
    chk("job_done", 64'(done_o), 64'd1);
    chk("job_done_valid", 64'(lane_valid_o), 64'd0);
    tick();
    chk("job_idle_done", 64'(done_o), 64'd0);
    chk("job_idle_busy", 64'(busy_o), 64'd0);
  endtask

  initial begin
    repeat (3) tick();
    rst_ni = 1'b1;
    tick();

    // Reset state
    chk("rst_valid", 64'(lane_valid_o), 64'd0);
    chk("rst_data_nz", 64'(|lane_data_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
    chk("rst_stall", 64'(stall_cnt_o), 64'd0);
`endif

    // len=32, all lanes ready, input valid every cycle
    lane_ready_i = '1;
    run_job(32, 32'hA000_0000, -1);

    // len=20 with lane 3 backpressured
    lane_ready_i = 16'hFFF7;
    len_i   = CW'(20);
    start_i = 1'b1;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 19; i++) begin
      chk("t2_ready", 64'(in_ready_o), 64'd1);
      in_data_i = 32'hB000_0000 + DW'(i);
      tick();
      chk("t2_valid", 64'(lane_valid_o[i % N]), 64'd1);
      chk("t2_data", 64'(lane_word(i % N)), 64'(32'hB000_0000 + DW'(i)));
    end
    in_data_i = 32'hB000_0013;
    chk("t2_stall", 64'(in_ready_o), 64'd0);
    repeat (3) tick();
    chk("t2_stall_hold", 64'(in_ready_o), 64'd0);
    chk("t2_stall_valid", 64'(lane_valid_o), 64'h0008);
    chk("t2_lane3_old", 64'(lane_word(3)), 64'hB000_0003);
    lane_ready_i[3] = 1'b1;
    #1;
    chk("t2_ready_comb", 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i      = 1'b0;
    lane_ready_i[3] = 1'b0;
    chk("t2_reload_valid", 64'(lane_valid_o), 64'h0008);
    chk("t2_reload_data", 64'(lane_word(3)), 64'hB000_0013);
    chk("t2_drain_ready", 64'(in_ready_o), 64'd0);
    chk("t2_drain_busy", 64'(busy_o), 64'd1);
    repeat (2) tick();
    chk("t2_drain_hold", 64'(lane_valid_o), 64'h0008);
    chk("t2_drain_nodone", 64'(done_o), 64'd0);
    lane_ready_i[3] = 1'b1;
    tick();
    chk("t2_done", 64'(done_o), 64'd1);
    chk("t2_done_valid", 64'(lane_valid_o), 64'd0);
    tick();
    chk("t2_idle_done", 64'(done_o), 64'd0);
    chk("t2_idle_busy", 64'(busy_o), 64'd0);

    // Zero-length job
    len_i   = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t3_busy", 64'(busy_o), 64'd1);
    chk("t3_done", 64'(done_o), 64'd1);
    chk("t3_valid", 64'(lane_valid_o), 64'd0);
    tick();
    chk("t3_busy_after", 64'(busy_o), 64'd0);
    chk("t3_done_after", 64'(done_o), 64'd0);
    chk("t3_valid_after", 64'(lane_valid_o), 64'd0);

    // Clear mid-run after 7 words, then restart at lane 0
    lane_ready_i = '0;
    len_i   = CW'(40);
    start_i = 1'b1;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_data_i = 32'hC000_0000 + DW'(i);
      tick();
    end
    chk("t4_held", 64'(lane_valid_o), 64'h007F);
    clear_i    = 1'b1;
    in_valid_i = 1'b0;
    tick();
    clear_i = 1'b0;
    chk("t4_clr_valid", 64'(lane_valid_o), 64'd0);
    chk("t4_clr_busy", 64'(busy_o), 64'd0);
    chk("t4_clr_done", 64'(done_o), 64'd0);
    tick();
    chk("t4_clr_nodone", 64'(done_o), 64'd0);
    lane_ready_i = '1;
    run_job(16, 32'hD000_0000, -1);

    // Stray start during RUN is ignored
    run_job(8, 32'hE000_0000, 2);

`ifdef MMUL_PARALLEL_LANE_DIST_PERF_EN
    // Lane 0 blocked for 10 cycles with input valid
    lane_ready_i = 16'hFFFE;
    len_i   = CW'(17);
    start_i = 1'b1;
    tick();
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data_i = 32'hF000_0000 + DW'(i);
      tick();
    end
    in_data_i = 32'hF000_0010;
    repeat (10) tick();
    chk("pf_stall10", 64'(stall_cnt_o), 64'd10);
    chk("pf_ready", 64'(in_ready_o), 64'd0);
    lane_ready_i[0] = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("pf_lane0", 64'(lane_word(0)), 64'hF000_0010);
    chk("pf_stall_keep", 64'(stall_cnt_o), 64'd10);
    tick();
    chk("pf_done", 64'(done_o), 64'd1);
    tick();
    len_i   = '0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("pf_stall_clr", 64'(stall_cnt_o), 64'd0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
